// File: rtl/augment_pkg.sv
// Constants and state encoding shared by the augmentation stages
// (reader, writer and friends).
package augment_pkg;
  localparam int IMG_DIM    = 28;
  localparam int IMG_PIXELS = 784;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} flip_state_t;
endpackage

// File: rtl/flip_read_valid_delay.sv
// DEPTH-stage shift register carrying {valid, last} alongside the BRAM read pipeline.
// valid_pre taps the stage just before the output, i.e. the cycle bram_data is good.
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  input  logic last_in,
  output logic valid_pre,
  output logic valid_out,
  output logic last_out
);
  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] last_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else begin
      valid_sr <= {valid_sr[DEPTH-2:0], valid_in};
      last_sr  <= {last_sr[DEPTH-2:0], last_in};
    end
  end

  assign valid_pre = valid_sr[DEPTH-2];
  assign valid_out = valid_sr[DEPTH-1];
  assign last_out  = last_sr[DEPTH-1];
endmodule

// File: rtl/flip_read.sv
// Streams one 28x28 image out of BRAM in raster / mirrored / rotated order,
// alternating between two ping-pong source locations.
module flip_read
  import augment_pkg::*;
#(
  parameter int                  DATA_WIDTH   = 8,
  parameter int                  ADDR_WIDTH   = 11,
  parameter logic [ADDR_WIDTH-1:0] INPUT_ADDR = 11'h0,
  parameter int                  PIXEL_SIZE   = 8,
  parameter int                  READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flip_h,
  input  logic                  flip_v,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  r_enable,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic [PIXEL_SIZE-1:0] pixel,
  output logic                  pixel_valid,
  output logic                  busy,
  output logic                  image_done
);
  localparam logic [4:0] LAST_IDX = 5'(IMG_DIM - 1);

  flip_state_t state, next_state;
  logic [4:0]  row, col;
  logic        fh_q, fv_q;
  logic        image;
  logic        last_read;
  logic        valid_pre, last_out;

  logic [4:0]            row_e, col_e;
  logic [ADDR_WIDTH-1:0] row_w, row_x28, image_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      fh_q  <= 1'b0;
      fv_q  <= 1'b0;
      image <= 1'b0;
      pixel <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            fh_q <= flip_h;
            fv_q <= flip_v;
            row  <= '0;
            col  <= '0;
          end
        end
        READ: begin
          if (col == LAST_IDX) begin
            col <= '0;
            // Wrap row too on the final read so the counters sit at 0 while idle.
            row <= (row == LAST_IDX) ? 5'd0 : row + 5'd1;
          end else begin
            col <= col + 5'd1;
          end
        end
        DRAIN: begin
          if (last_out) image <= ~image;
        end
        default: ;
      endcase
      if (valid_pre) pixel <= PIXEL_SIZE'(bram_data);
    end
  end

  always_comb begin
    next_state = state;
    r_enable   = 1'b0;
    busy       = 1'b1;
    last_read  = 1'b0;
    image_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = READ;
      end
      READ: begin
        r_enable = 1'b1;
        if (row == LAST_IDX && col == LAST_IDX) begin
          last_read  = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (last_out) begin
          image_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // row_e*28 built from shifts: 28 = 16 + 8 + 4.
  always_comb begin
    row_e      = fv_q ? LAST_IDX - row : row;
    col_e      = fh_q ? LAST_IDX - col : col;
    row_w      = ADDR_WIDTH'(row_e);
    row_x28    = (row_w << 4) + (row_w << 3) + (row_w << 2);
    image_base = image ? ADDR_WIDTH'(IMG_PIXELS) : '0;
    bram_addr  = INPUT_ADDR + image_base + row_x28 + ADDR_WIDTH'(col_e);
  end

  valid_delay #(
    .DEPTH(READ_LATENCY + 1)
  ) u_valid_delay (
    .clk      (clk),
    .reset    (reset),
    .valid_in (r_enable),
    .last_in  (last_read),
    .valid_pre(valid_pre),
    .valid_out(pixel_valid),
    .last_out (last_out)
  );
endmodule

// File: tb/tb_flip_read.sv
// Directed bench for flip_read: table of hand-computed pixels per flip mode
// plus hand-written sequences for ping-pong, ignored inputs and mid-image reset.
module tb_flip_read;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flip_h = 1'b0;
  logic        flip_v = 1'b0;
  logic [10:0] bram_addr;
  logic        r_enable;
  logic [7:0]  bram_data = 8'h00;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        busy;
  logic        image_done;

  flip_read #(
    .DATA_WIDTH(8), .ADDR_WIDTH(11), .INPUT_ADDR(11'h0), .PIXEL_SIZE(8), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .flip_h(flip_h), .flip_v(flip_v),
    .bram_addr(bram_addr), .r_enable(r_enable), .bram_data(bram_data),
    .pixel(pixel), .pixel_valid(pixel_valid), .busy(busy), .image_done(image_done)
  );

  always #5 clk = ~clk;

  // One-cycle BRAM, mem[a] = a[7:0].
  always @(posedge clk) if (r_enable) bram_data <= bram_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [7:0]  cap [784];
  logic [10:0] addr_log [784];
  int nvalid, nreads, gaps, first_valid_cyc, last_valid_cyc, done_cnt, done_at_valid;
  int done_cyc_q[$];
  int first_addr_q[$];
  logic prev_ren = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid) begin
        if (nvalid > 0 && last_valid_cyc != cyc - 1) gaps++;
        if (nvalid == 0) first_valid_cyc = cyc;
        if (nvalid < 784) cap[nvalid] = pixel;
        nvalid++;
        last_valid_cyc = cyc;
      end
      if (image_done) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
        done_at_valid = nvalid;
      end
      if (r_enable) begin
        if (!prev_ren) first_addr_q.push_back(int'(bram_addr));
        if (nreads < 784) addr_log[nreads] = bram_addr;
        nreads++;
      end
    end
    prev_ren = r_enable;
  end

  typedef struct {
    logic       fh;
    logic       fv;
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [16];

  int start_cyc;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  task automatic clear_monitor();
    nvalid = 0; nreads = 0; gaps = 0; first_valid_cyc = -1; last_valid_cyc = -1;
    done_cnt = 0; done_at_valid = -1;
    done_cyc_q.delete();
    first_addr_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; flip_h = 1'b0; flip_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_monitor();
  endtask

  task automatic apply_stimulus(input logic fh, input logic fv);
    @(posedge clk); #1;
    flip_h = fh; flip_v = fv; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; flip_h = 1'b0; flip_v = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    for (k = 0; k < budget && done_cnt < n; k++) @(posedge clk);
    #1;
    if (done_cnt < n) check_output("done_timeout", done_cnt, n);
  endtask

  // Reference address for raster position k of an image.
  function automatic int ref_addr(input int base, input logic fh, input logic fv, input int k);
    int r, c;
    r = k / 28;
    c = k % 28;
    if (fv) r = 27 - r;
    if (fh) c = 27 - c;
    return base + r * 28 + c;
  endfunction

  initial begin
    int errs, hits;
    logic fh, fv;
    vecs[0]  = '{1'b0, 1'b0,   0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0,   1, 8'h01};
    vecs[2]  = '{1'b0, 1'b0, 255, 8'hFF};
    vecs[3]  = '{1'b0, 1'b0, 256, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 783, 8'h0F};
    vecs[5]  = '{1'b1, 1'b0,   0, 8'd27};
    vecs[6]  = '{1'b1, 1'b0,   1, 8'd26};
    vecs[7]  = '{1'b1, 1'b0,  27, 8'd0};
    vecs[8]  = '{1'b1, 1'b0,  28, 8'd55};
    vecs[9]  = '{1'b1, 1'b0, 783, 8'hF4};
    vecs[10] = '{1'b1, 1'b1,   0, 8'h0F};
    vecs[11] = '{1'b1, 1'b1,   1, 8'h0E};
    vecs[12] = '{1'b1, 1'b1,  28, 8'hF3};
    vecs[13] = '{1'b1, 1'b1, 783, 8'h00};
    vecs[14] = '{1'b0, 1'b1,   0, 8'hF4};
    vecs[15] = '{1'b0, 1'b1, 783, 8'h1B};

    clear_monitor();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_addr", int'(bram_addr), 0);
    check_output("rst_ren", int'(r_enable), 0);
    check_output("rst_pixel", int'(pixel), 0);
    check_output("rst_valid", int'(pixel_valid), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(image_done), 0);

    for (int c = 0; c < 4; c++) begin
      fh = c[0];
      fv = c[1];
      do_reset();
      apply_stimulus(fh, fv);
      check_output("busy_after_start", int'(busy), 1);
      wait_done(1, 1200);
      check_output("first_valid_lat", first_valid_cyc - start_cyc, L + 2);
      check_output("done_cycle", done_cyc_q.size() > 0 ? done_cyc_q[0] - start_cyc : -1, 785 + L);
      check_output("valid_count", nvalid, 784);
      check_output("valid_gaps", gaps, 0);
      check_output("done_on_last", done_at_valid, 784);
      errs = 0;
      for (int k = 0; k < 784; k++)
        if (cap[k] !== 8'(ref_addr(0, fh, fv, k))) errs++;
      check_output("pixel_seq", errs, 0);
      hits = 0;
      for (int i = 0; i < 16; i++) begin
        if (vecs[i].fh == fh && vecs[i].fv == fv) begin
          check_output($sformatf("vec%0d_pix%0d", i, vecs[i].idx), int'(cap[vecs[i].idx]),
                       int'(vecs[i].exp));
          hits++;
        end
      end
      if (fh && fv) begin
        errs = 0;
        for (int k = 0; k < 784; k++) if (int'(addr_log[k]) != 783 - k) errs++;
        check_output("rot_addr_seq", errs, 0);
      end
      @(posedge clk); #1;
      check_output("idle_busy", int'(busy), 0);
    end

    // Ping-pong: start held high so each IDLE cycle re-accepts immediately.
    do_reset();
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 3000 && first_addr_q.size() < 3; k++) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, 1200);
    repeat (5) @(posedge clk);
    #1;
    check_output("pp_first_addr0", first_addr_q.size() > 0 ? first_addr_q[0] : -1, 0);
    check_output("pp_first_addr1", first_addr_q.size() > 1 ? first_addr_q[1] : -1, 784);
    check_output("pp_first_addr2", first_addr_q.size() > 2 ? first_addr_q[2] : -1, 0);
    check_output("pp_done_cnt", done_cnt, 3);
    check_output("pp_gap01", done_cyc_q.size() > 1 ? done_cyc_q[1] - done_cyc_q[0] : -1, 786 + L);
    check_output("pp_gap12", done_cyc_q.size() > 2 ? done_cyc_q[2] - done_cyc_q[1] : -1, 786 + L);

    // start and flip_h disturbed mid-image must change nothing.
    do_reset();
    apply_stimulus(1'b0, 1'b0);
    for (int k = 0; k < 1000 && nreads < 300; k++) begin @(negedge clk); #1; end
    start = 1'b1; flip_h = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flip_h = 1'b0;
    wait_done(1, 1200);
    repeat (20) @(posedge clk);
    #1;
    errs = 0;
    for (int k = 0; k < 784; k++) if (int'(addr_log[k]) != k) errs++;
    check_output("ign_addr_seq", errs, 0);
    check_output("ign_reads", nreads, 784);
    check_output("ign_done_cnt", done_cnt, 1);
    apply_stimulus(1'b0, 1'b0);
    wait_done(2, 1200);
    check_output("ign_next_base", first_addr_q.size() > 1 ? first_addr_q[1] : -1, 784);

    // Reset at the 400th valid pixel aborts the image and restores location 0.
    do_reset();
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    for (int k = 0; k < 1000 && nvalid < 400; k++) begin @(negedge clk); #1; end
    check_output("mid_reached_400", nvalid, 400);
    reset = 1'b1;
    @(posedge clk); #1;
    check_output("mid_valid", int'(pixel_valid), 0);
    check_output("mid_busy", int'(busy), 0);
    check_output("mid_ren", int'(r_enable), 0);
    reset = 1'b0;
    repeat (800) @(posedge clk);
    #1;
    check_output("mid_no_done", done_cnt, 0);
    first_addr_q.delete();
    apply_stimulus(1'b0, 1'b0);
    @(negedge clk); #1;
    check_output("mid_restart_addr", first_addr_q.size() > 0 ? first_addr_q[0] : -1, 0);
    wait_done(1, 1200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
